// File: rtl/sram_arbiter_2x1_pkg.sv
// Shared definitions for the 2:1 sram-like bus arbiter: FSM encoding,
// port identifiers and the bus size code used for instruction fetches.
package sram_arbiter_2x1_pkg;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } arb_state_e;

    // Port identifiers, used for both the owner and last registers.
    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    // Bus size code for a 32-bit access.
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Grant selection: a lone requester wins; on a tie the port that was
    // not granted most recently wins. Only meaningful when a request exists.
    function automatic logic pick_port(input logic req_inst,
                                       input logic req_data,
                                       input logic last_port);
        logic sel;
        if (req_inst && req_data) begin
            sel = ~last_port;
        end else if (req_data) begin
            sel = PORT_DATA;
        end else begin
            sel = PORT_INST;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sram_arbiter_2x1.sv
// 2:1 arbiter merging an instruction-fetch port and a data port onto one
// sram-like master. One transaction outstanding at a time; grant is
// combinational in IDLE, with round-robin on ties.
module sram_arbiter_2x1
    import sram_arbiter_2x1_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok
);

    // Seeding last with the opposite port makes the first tie go to the
    // preferred side.
    localparam logic LAST_RST = (DATA_FIRST != 1'b0) ? PORT_INST : PORT_DATA;

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;

    logic       grant_vld_s;
    logic       grant_port_s;
    logic       handshake_s;
    logic       zero_lat_done_s;
    logic       wait_done_s;
    logic       grant_inst_s;
    logic       grant_data_s;

    // Grant selection and next-state for the state/owner/last registers.
    always_comb begin
        grant_vld_s  = 1'b0;
        grant_port_s = PORT_INST;
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        case (state_q)
            ST_IDLE: begin
                grant_vld_s  = inst_req | data_req;
                grant_port_s = pick_port(inst_req, data_req, last_q);
                if (grant_vld_s && bus_addr_ok) begin
                    owner_d = grant_port_s;
                    last_d  = grant_port_s;
                    // A slave answering data in the address cycle finishes
                    // the transaction immediately, so no wait state.
                    if (bus_data_ok) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (bus_data_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, owner and last registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= PORT_INST;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // grant_vld_s is only ever set in IDLE, so it also gates the bus to 0
    // while waiting for data.
    assign grant_inst_s    = grant_vld_s & (grant_port_s == PORT_INST);
    assign grant_data_s    = grant_vld_s & (grant_port_s == PORT_DATA);
    assign handshake_s     = grant_vld_s & bus_addr_ok;
    assign zero_lat_done_s = handshake_s & bus_data_ok;
    assign wait_done_s     = (state_q == ST_WAIT_DATA) & bus_data_ok;

    assign bus_req   = grant_vld_s;
    assign bus_wr    = grant_data_s ? data_wr    : 1'b0;
    assign bus_size  = grant_data_s ? data_size  : (grant_inst_s ? SIZE_WORD : 2'b00);
    assign bus_addr  = grant_data_s ? data_addr  : (grant_inst_s ? inst_addr : 32'h0000_0000);
    assign bus_wdata = grant_data_s ? data_wdata : 32'h0000_0000;

    assign inst_addr_ok = handshake_s & (grant_port_s == PORT_INST);
    assign data_addr_ok = handshake_s & (grant_port_s == PORT_DATA);

    assign inst_data_ok = (zero_lat_done_s & (grant_port_s == PORT_INST))
                        | (wait_done_s     & (owner_q      == PORT_INST));
    assign data_data_ok = (zero_lat_done_s & (grant_port_s == PORT_DATA))
                        | (wait_done_s     & (owner_q      == PORT_DATA));

    // Read data is shared; each consumer qualifies it with its own data_ok.
    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_arbiter_2x1.sv
// Directed bench for sram_arbiter_2x1: two requester agents, a slave with
// programmable latency, and a scoreboard of expected bus transactions in
// grant order.
module tb_sram_arbiter_2x1;
    import sram_arbiter_2x1_pkg::*;

    typedef struct {
        logic        port;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;

    sram_arbiter_2x1 #(.DATA_FIRST(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    int n_cmp = 0;
    int n_mis = 0;

    txn_t        exp_q[$];
    txn_t        out_q[$];
    logic [31:0] inst_pend_q[$];
    txn_t        data_pend_q[$];

    logic m_ia = 1'b0;
    logic m_da = 1'b0;
    int   c_ia = 0, c_da = 0, c_id = 0, c_dd = 0, c_notidle = 0;

    int   sl_alat = 0;
    int   sl_dlat = 1;
    bit   sl_busy = 1'b0;
    int   sl_wcnt = 0;
    int   sl_dcnt = 0;
    logic [31:0] sl_rdata = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        logic [31:0] r;
        if (a == 32'hBFC0_0000) r = 32'h2408_0001;
        else                    r = {a[15:0], ~a[31:16]};
        return r;
    endfunction

    task automatic exp_inst(input logic [31:0] a);
        txn_t t;
        t.port = 1'b0; t.wr = 1'b0; t.size = 2'd2; t.addr = a; t.wdata = 32'h0;
        exp_q.push_back(t);
    endtask

    task automatic exp_data(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.port = 1'b1; t.wr = w; t.size = s; t.addr = a; t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic req_data(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.port = 1'b1; t.wr = w; t.size = s; t.addr = a; t.wdata = d;
        data_pend_q.push_back(t);
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic clear_counts();
        c_ia = 0; c_da = 0; c_id = 0; c_dd = 0; c_notidle = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_q.size() != 0 || inst_pend_q.size() != 0 ||
                data_pend_q.size() != 0 || sl_busy) && n < max_cyc) begin
            step();
            n++;
        end
        if (n >= max_cyc) begin
            check("drain_timeout", 64'(exp_q.size() + out_q.size()), 64'd0);
            exp_q.delete(); out_q.delete(); inst_pend_q.delete(); data_pend_q.delete();
        end
        step();
    endtask

    initial begin : clkgen
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : inst_agent
        inst_req = 1'b0; inst_addr = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (inst_req && m_ia) inst_req = 1'b0;
            if (!inst_req && inst_pend_q.size() > 0) begin
                inst_addr = inst_pend_q.pop_front();
                inst_req  = 1'b1;
            end
        end
    end

    initial begin : data_agent
        txn_t t;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (data_req && m_da) data_req = 1'b0;
            if (!data_req && data_pend_q.size() > 0) begin
                t = data_pend_q.pop_front();
                data_wr = t.wr; data_size = t.size; data_addr = t.addr; data_wdata = t.wdata;
                data_req = 1'b1;
            end
        end
    end

    initial begin : slave
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
            if (sl_busy) begin
                if (sl_dcnt == 0) begin
                    bus_data_ok = 1'b1; bus_rdata = sl_rdata; sl_busy = 1'b0;
                end else begin
                    sl_dcnt--;
                end
            end else if (bus_req === 1'b1 && resetn === 1'b1) begin
                if (sl_wcnt >= sl_alat) begin
                    bus_addr_ok = 1'b1; sl_wcnt = 0;
                    if (sl_dlat == 0) begin
                        bus_data_ok = 1'b1; bus_rdata = rdata_of(bus_addr);
                    end else begin
                        sl_busy = 1'b1; sl_dcnt = sl_dlat - 1; sl_rdata = rdata_of(bus_addr);
                    end
                end else begin
                    sl_wcnt++;
                end
            end else begin
                sl_wcnt = 0;
            end
        end
    end

    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            m_ia = inst_addr_ok;
            m_da = data_addr_ok;
            c_ia += int'(inst_addr_ok);
            c_da += int'(data_addr_ok);
            c_id += int'(inst_data_ok);
            c_dd += int'(data_data_ok);
            if (dut.state_q != ST_IDLE) c_notidle++;
            if (bus_req && bus_addr_ok) begin
                check("one_outstanding", 64'(out_q.size()), 64'd0);
                if (exp_q.size() == 0) begin
                    check("grant_without_expectation", 64'(exp_q.size()), 64'd1);
                end else begin
                    t = exp_q.pop_front();
                    check("grant_port", {62'd0, inst_addr_ok, data_addr_ok},
                          {62'd0, t.port == 1'b0, t.port == 1'b1});
                    check("bus_wr", {63'd0, bus_wr}, {63'd0, t.wr});
                    check("bus_size", {62'd0, bus_size}, {62'd0, t.size});
                    check("bus_addr", {32'd0, bus_addr}, {32'd0, t.addr});
                    check("bus_wdata", {32'd0, bus_wdata}, {32'd0, t.wdata});
                    out_q.push_back(t);
                end
            end else if (inst_addr_ok || data_addr_ok) begin
                check("stray_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd0);
            end
            if (inst_data_ok || data_data_ok) begin
                if (out_q.size() == 0) begin
                    check("stray_data_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
                end else begin
                    t = out_q.pop_front();
                    check("data_ok_port", {62'd0, inst_data_ok, data_data_ok},
                          {62'd0, t.port == 1'b0, t.port == 1'b1});
                    check("rdata", {32'd0, (t.port == 1'b0) ? inst_rdata : data_rdata},
                          {32'd0, rdata_of(t.addr)});
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        resetn = 1'b0;
        step(); step(); step();

        // Reset state with no requests: everything quiet.
        check("rst_bus_req",   {63'd0, bus_req}, 64'd0);
        check("rst_bus_wr",    {63'd0, bus_wr}, 64'd0);
        check("rst_bus_size",  {62'd0, bus_size}, 64'd0);
        check("rst_bus_addr",  {32'd0, bus_addr}, 64'd0);
        check("rst_bus_wdata", {32'd0, bus_wdata}, 64'd0);
        check("rst_oks", {60'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 64'd0);
        check("rst_state", {63'd0, dut.state_q}, 64'd0);
        resetn = 1'b1;
        step();

        // Single inst fetch, addr_ok after 2 cycles, data 3 cycles later.
        clear_counts();
        sl_alat = 2; sl_dlat = 3;
        exp_inst(32'hBFC0_0000);
        inst_pend_q.push_back(32'hBFC0_0000);
        drain(50);
        check("fetch_ia_cnt", 64'(c_ia), 64'd1);
        check("fetch_id_cnt", 64'(c_id), 64'd1);
        check("fetch_data_side", 64'(c_da + c_dd), 64'd0);

        // Tie straight after reset: data first, then inst.
        do_reset();
        step();
        clear_counts();
        sl_alat = 0; sl_dlat = 1;
        exp_data(1'b0, 2'd2, 32'h8000_0010, 32'h1111_1111);
        exp_inst(32'hBFC0_0004);
        req_data(1'b0, 2'd2, 32'h8000_0010, 32'h1111_1111);
        inst_pend_q.push_back(32'hBFC0_0004);
        drain(50);
        check("tie_dd_cnt", 64'(c_dd), 64'd1);
        check("tie_id_cnt", 64'(c_id), 64'd1);

        // Back-to-back ties alternate D, I, D, I, ...
        clear_counts();
        sl_alat = 1; sl_dlat = 2;
        for (int k = 0; k < 4; k++) begin
            exp_data(k[0], 2'd2, 32'h8000_0100 + 32'(k * 4), 32'hC0DE_0000 + 32'(k));
            exp_inst(32'hBFC0_0100 + 32'(k * 4));
            req_data(k[0], 2'd2, 32'h8000_0100 + 32'(k * 4), 32'hC0DE_0000 + 32'(k));
            inst_pend_q.push_back(32'hBFC0_0100 + 32'(k * 4));
        end
        drain(200);
        check("b2b_ia_cnt", 64'(c_ia), 64'd4);
        check("b2b_da_cnt", 64'(c_da), 64'd4);
        check("b2b_dok_cnt", 64'(c_id + c_dd), 64'd8);

        // Byte store.
        clear_counts();
        sl_alat = 1; sl_dlat = 1;
        exp_data(1'b1, 2'd0, 32'h8000_1003, 32'h0000_00AB);
        req_data(1'b1, 2'd0, 32'h8000_1003, 32'h0000_00AB);
        drain(50);
        check("store_dd_cnt", 64'(c_dd), 64'd1);
        check("store_id_cnt", 64'(c_id), 64'd0);

        // Zero-latency slave: three inst reads without leaving IDLE.
        clear_counts();
        sl_alat = 0; sl_dlat = 0;
        for (int k = 0; k < 3; k++) begin
            exp_inst(32'hBFC0_0200 + 32'(k * 4));
            inst_pend_q.push_back(32'hBFC0_0200 + 32'(k * 4));
        end
        drain(50);
        check("zl_id_cnt", 64'(c_id), 64'd3);
        check("zl_not_idle", 64'(c_notidle), 64'd0);

        // Reset while waiting for data; late data_ok must be dropped.
        clear_counts();
        sl_alat = 0; sl_dlat = 6;
        exp_inst(32'hBFC0_0020);
        inst_pend_q.push_back(32'hBFC0_0020);
        n = 0;
        while (out_q.size() == 0 && n < 20) begin step(); n++; end
        if (n >= 20) check("rst_mid_handshake_timeout", 64'(out_q.size()), 64'd1);
        step();
        check("rst_mid_in_wait", {63'd0, dut.state_q}, {63'd0, ST_WAIT_DATA});
        out_q.delete();
        do_reset();
        check("rst_mid_idle", {63'd0, dut.state_q}, {63'd0, ST_IDLE});
        n = 0;
        while (sl_busy && n < 20) begin step(); n++; end
        if (n >= 20) check("rst_mid_slave_timeout", {63'd0, sl_busy}, 64'd0);
        step();
        check("rst_mid_no_dok", 64'(c_id + c_dd), 64'd0);
        check("rst_mid_state", {63'd0, dut.state_q}, {63'd0, ST_IDLE});
        sl_dlat = 2;
        exp_data(1'b0, 2'd1, 32'h8000_2002, 32'h0000_5555);
        req_data(1'b0, 2'd1, 32'h8000_2002, 32'h0000_5555);
        drain(50);
        check("rst_mid_next_dd", 64'(c_dd), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_2x1.md
SRAM_ARBITER_2X1 -- requirements
Module: sram_arbiter_2x1

Interface
REQ-001 SHALL have parameter DATA_FIRST, default 1: when 1, the first tie after reset goes to the data port; when 0, it goes to the inst port.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port inst_req, input, 1 bit: instruction-fetch request (read-only, word size).
REQ-005 SHALL have port inst_addr, input, 32 bits: fetch address.
REQ-006 SHALL have port inst_rdata, output, 32 bits: fetch read data.
REQ-007 SHALL have port inst_addr_ok, output, 1 bit: fetch address accepted.
REQ-008 SHALL have port inst_data_ok, output, 1 bit: fetch data valid.
REQ-009 SHALL have port data_req, input, 1 bit: data-side request.
REQ-010 SHALL have port data_wr, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port data_size, input, 2 bits: 0 = byte, 1 = half, 2 = word.
REQ-012 SHALL have port data_addr, input, 32 bits: data address.
REQ-013 SHALL have port data_wdata, input, 32 bits: write data.
REQ-014 SHALL have port data_rdata, output, 32 bits: read data.
REQ-015 SHALL have port data_addr_ok, output, 1 bit: data address accepted.
REQ-016 SHALL have port data_data_ok, output, 1 bit: data transaction complete.
REQ-017 SHALL have ports bus_req, bus_wr, bus_size[1:0], bus_addr[31:0] and bus_wdata[31:0], all outputs: the shared sram-like master, same meanings as the data-side request ports.
REQ-018 SHALL have ports bus_rdata[31:0], bus_addr_ok and bus_data_ok, all inputs: the shared bus responses.

Function
REQ-019 SHALL implement FSM states IDLE and WAIT_DATA, with registers owner (0 = inst, 1 = data) and last (the most recently granted port).
REQ-020 In IDLE, grant SHALL go to the only requester, or, when inst_req and data_req are both high, to the port other than last; grant is combinational from the current requests and last.
REQ-021 In IDLE with a grant, SHALL drive bus_req = 1 and the granted port's wr/size/addr/wdata; an inst grant drives wr = 0, size = 2, wdata = 0.
REQ-022 In IDLE with no request, and in WAIT_DATA, SHALL drive all bus_* outputs to 0.
REQ-023 SHALL route bus_addr_ok only to the granted port's addr_ok, in IDLE only; the other addr_ok SHALL stay 0.
REQ-024 On an IDLE handshake (bus_req & bus_addr_ok), SHALL set owner and last to the granted port and go to WAIT_DATA on the next edge.
REQ-025 In WAIT_DATA, SHALL route bus_data_ok to owner's data_ok only, and SHALL return to IDLE on bus_data_ok; a new grant is possible no earlier than the next cycle.
REQ-026 Zero-latency case: bus_addr_ok and bus_data_ok high together in IDLE with a grant SHALL complete the transaction that cycle; data_ok goes to the granted port, last updates, state stays IDLE.
REQ-027 bus_data_ok in IDLE without a handshake SHALL be ignored; bus_addr_ok in WAIT_DATA SHALL be ignored.
REQ-028 bus_rdata SHALL drive inst_rdata and data_rdata unmodified and combinationally; consumers qualify it with data_ok.
REQ-029 At most one transaction SHALL be outstanding; a requester holds req and its fields stable until it sees addr_ok.

Reset
REQ-030 On resetn low, SHALL asynchronously set state = IDLE, owner = 0, and last = inst if DATA_FIRST = 1 else data; an in-flight transaction is abandoned and its data_ok is never forwarded.
REQ-031 During reset, all outputs SHALL follow the IDLE rules, so they are 0 unless a req input is high.

Structure
REQ-032 The state encoding, the port-ID constants (INST = 0, DATA = 1) and the SIZE_WORD = 2 constant SHALL live in the shared CPU package.
REQ-033 Implementation SHALL be a single module: FSM and grant logic in one always block with async reset, and the mux as continuous assignments; no sub-module.

Verification
REQ-034 Single inst fetch: inst_req with addr 0xBFC00000, bus_addr_ok after 2 cycles, bus_data_ok with rdata 0x24080001 after 3 more cycles -> inst_addr_ok one pulse, inst_data_ok one pulse with 0x24080001, data_* outputs stay 0.
REQ-035 Tie after reset (DATA_FIRST = 1): inst_req and data_req both high -> data granted first (bus_wr/size/addr from the data port); after its data_ok, inst is granted next.
REQ-036 Back-to-back ties: each side issues 4 requests -> grants alternate D, I, D, I, D, I, D, I, with never two addr_ok pulses while one transaction is outstanding.
REQ-037 Data store: data_wr = 1, size = 0, addr 0x80001003, wdata 0xAB -> bus carries identical fields; data_data_ok is returned and inst_data_ok stays 0.
REQ-038 Zero-latency slave (bus_addr_ok and bus_data_ok high in the same cycle): 3 inst reads -> 3 data_ok pulses and the FSM never leaves IDLE.
REQ-039 Reset mid-transaction: resetn dropped while in WAIT_DATA, then bus_data_ok arrives after release -> state is IDLE, no data_ok is forwarded, and the next request is granted normally.
